// File: rtl/ethernet_st_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_IN Avalon-ST sources onto one TX stream.
// The grant is held from SOP to EOP, orphan beats are flushed while idle, and each port has statistics counters.
//
// state | meaning
// IDLE  | no packet in flight; flush orphan beats and pick the next SOP requester
// BUSY  | grant_id owns the output combinationally until its EOP beat transfers
module ethernet_st_packet_arbiter #(
  parameter int NUM_IN  = 2,
  parameter int DATA_W  = 32,
  parameter int ERR_W   = 6,
  parameter int EMPTY_W = 2,
  parameter int CNT_W   = 16,
  localparam int GNT_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN*ERR_W-1:0]    in_error,
  input  logic [NUM_IN-1:0]          in_startofpacket,
  input  logic [NUM_IN-1:0]          in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0]  in_empty,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ERR_W-1:0]           out_error,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic [GNT_W-1:0]           grant_id,
  output logic                       busy,
  output logic [NUM_IN*CNT_W-1:0]    pkt_count,
  output logic [NUM_IN*CNT_W-1:0]    drop_count,
  input  logic                       clear_stats
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [GNT_W-1:0]  grant_d;
  logic [GNT_W-1:0]  cand;
  logic              found;
  logic [NUM_IN-1:0] req, orphan;
  logic              xfer_last;
  logic [CNT_W-1:0]  pkt_cnt  [NUM_IN];
  logic [CNT_W-1:0]  drop_cnt [NUM_IN];

  assign req       = in_valid & in_startofpacket;
  assign orphan    = in_valid & ~in_startofpacket;
  assign busy      = (state_q == BUSY);
  assign xfer_last = busy && in_valid[grant_id] && out_ready && in_endofpacket[grant_id];

  // Round-robin search starts one past the last winner, so the previous owner goes last.
  always_comb begin
    grant_d = grant_id;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = GNT_W'((int'(grant_id) + k) % NUM_IN);
      if (!found && req[cand]) begin
        found   = 1'b1;
        grant_d = cand;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    in_ready          = '0;
    out_valid         = 1'b0;
    out_data          = '0;
    out_error         = '0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    case (state_q)
      IDLE: begin
        in_ready = orphan;
        if (found) state_d = BUSY;
      end
      BUSY: begin
        out_valid          = in_valid[grant_id];
        out_data           = in_data[int'(grant_id)*DATA_W +: DATA_W];
        out_error          = in_error[int'(grant_id)*ERR_W +: ERR_W];
        out_startofpacket  = in_startofpacket[grant_id];
        out_endofpacket    = in_endofpacket[grant_id];
        out_empty          = in_empty[int'(grant_id)*EMPTY_W +: EMPTY_W];
        in_ready[grant_id] = out_ready;
        if (xfer_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_id <= GNT_W'(NUM_IN - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) grant_id <= grant_d;
    end
  end

  // clear_stats takes priority over a coincident increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      if (reset || clear_stats) begin
        pkt_cnt[i]  <= '0;
        drop_cnt[i] <= '0;
      end else begin
        if (xfer_last && int'(grant_id) == i) pkt_cnt[i] <= pkt_cnt[i] + CNT_W'(1);
        if (!busy && orphan[i]) drop_cnt[i] <= drop_cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_pack
    assign pkt_count[gi*CNT_W +: CNT_W]  = pkt_cnt[gi];
    assign drop_count[gi*CNT_W +: CNT_W] = drop_cnt[gi];
  end

endmodule
